// File: rtl/hif_queue_seq.sv
// hif_queue_seq: write/read pointer sequencer for the HF sample RAM, issuing a read burst of the newest RD_LEN samples after each write.
// Build option QSEQ_PEND_EN adds a one-deep pending strobe; without it, strobes arriving while busy are dropped.
module hif_queue_seq #(
    parameter int DEPTH  = 1536,
    parameter int AW     = 11,
    parameter int RD_LEN = 1021
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrt_smpl,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          sequencing,
    output logic          first,
    output logic          last,
    output logic          full,
    output logic          ovr
);
    localparam int            CW      = $clog2(RD_LEN + 1);
    localparam int            AW1     = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RD_LEN);
    localparam logic [CW-1:0] SEQ_END = CW'(RD_LEN - 1);
    localparam logic [AW-1:0] PTR_END = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);
    localparam logic [AW:0]   BACK    = AW1'(DEPTH - (RD_LEN - 1));

    typedef enum logic [1:0] {IDLE, WRITE, SEQ} state_t;

    state_t        state, nxt;
    logic [AW-1:0] new_ptr;
    logic [CW-1:0] cnt, cnt_nxt, scnt;
    logic          pend, busy, drop;
    logic [AW:0]   start_sum;
    logic [AW-1:0] start;

    assign busy      = state != IDLE;
    assign cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // The oldest sample of the burst sits RD_LEN-1 slots behind the one just written.
    assign start_sum = {1'b0, new_ptr} + BACK;
    assign start     = (start_sum >= DEPTH_W) ? AW'(start_sum - DEPTH_W) : start_sum[AW-1:0];

`ifdef QSEQ_PEND_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            pend <= 1'b0;
        else
            pend <= (state == IDLE) ? (pend && wrt_smpl) : (pend || wrt_smpl);
    assign drop = busy && wrt_smpl && pend;
`else
    assign pend = 1'b0;
    assign drop = busy && wrt_smpl;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;

    always_comb
        nxt = (state == IDLE)  ? ((wrt_smpl || pend) ? WRITE : IDLE) :
              (state == WRITE) ? ((cnt_nxt == CNT_MAX) ? SEQ : IDLE) :
              (state == SEQ && scnt != SEQ_END) ? SEQ : IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            new_ptr <= '0;
            cnt     <= '0;
            scnt    <= '0;
            waddr   <= '0;
            raddr   <= '0;
            ovr     <= 1'b0;
        end else begin
            if (state == IDLE && nxt == WRITE)
                waddr <= new_ptr;
            if (state == WRITE) begin
                new_ptr <= (new_ptr == PTR_END) ? '0 : new_ptr + 1'b1;
                cnt     <= cnt_nxt;
                if (nxt == SEQ)
                    raddr <= start;
            end
            if (state == SEQ && scnt != SEQ_END)
                raddr <= (raddr == PTR_END) ? '0 : raddr + 1'b1;
            scnt <= (state == SEQ) ? scnt + 1'b1 : '0;
            if (drop)
                ovr <= 1'b1;
        end

    always_comb begin
        we         = state == WRITE;
        sequencing = state == SEQ;
        first      = sequencing && scnt == '0;
        last       = sequencing && scnt == SEQ_END;
        full       = cnt == CNT_MAX;
    end
endmodule
